uart_tx: RTL

Serial transmitter that sits directly downstream of `BaudRateGenerator`. It consumes the generator's `bclk` output as its bit-timing reference and serialises parallel bytes into asynchronous UART frames on `tx`. Framing is start bit, LSB-first data, optional parity, then stop bits. Upstream logic supplies bytes through a valid/ready handshake.

---
 rtl/uart_tx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART frame serialiser paced by an external baud reference
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bclk,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);
    localparam int CW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state, state_n;
    logic                 bclk_q;
    logic                 live;
    logic                 tick;
    logic                 accept;
    logic                 last_stop;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [CW-1:0]        bitcnt, bitcnt_n;
    logic                 stopcnt, stopcnt_n;
    logic                 par, par_n;
    logic                 pend, pend_n;
    logic                 tx_n;
    logic                 busy_n;

    assign tick      = bclk & ~bclk_q;
    assign last_stop = (stopcnt == 1'(STOP_BITS - 1));
    // live holds ready low until the first clock after reset release
    assign ready     = live & ((state == S_IDLE) | ((state == S_STOP) & last_stop & ~pend));
    assign accept    = valid & ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            bclk_q  <= 1'b0;
            live    <= 1'b0;
            shreg   <= '0;
            bitcnt  <= '0;
            stopcnt <= 1'b0;
            par     <= 1'b0;
            pend    <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            bclk_q  <= bclk;
            live    <= 1'b1;
            shreg   <= shreg_n;
            bitcnt  <= bitcnt_n;
            stopcnt <= stopcnt_n;
            par     <= par_n;
            pend    <= pend_n;
            tx      <= tx_n;
            busy    <= busy_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bitcnt_n  = bitcnt;
        stopcnt_n = stopcnt;
        par_n     = par;
        pend_n    = pend;
        if (accept) begin
            shreg_n = data;
            par_n   = (PARITY == 2) ? ~^data : ^data;
        end
        case (state)
            S_IDLE:   if (accept) state_n = S_SYNC;
            S_SYNC:   if (tick) state_n = S_START;
            S_START:  if (tick) begin
                state_n  = S_DATA;
                bitcnt_n = '0;
            end
            S_DATA:   if (tick) begin
                shreg_n  = shreg >> 1;
                bitcnt_n = bitcnt + CW'(1);
                if (bitcnt == CW'(DATA_BITS - 1)) begin
                    state_n   = (PARITY != 0) ? S_PARITY : S_STOP;
                    stopcnt_n = 1'b0;
                end
            end
            S_PARITY: if (tick) begin
                state_n   = S_STOP;
                stopcnt_n = 1'b0;
            end
            S_STOP:   if (tick) begin
                if (last_stop) begin
                    stopcnt_n = 1'b0;
                    pend_n    = 1'b0;
                    // a byte taken during the final stop bit starts with no idle gap
                    state_n   = (pend | accept) ? S_START : S_IDLE;
                end else begin
                    stopcnt_n = 1'b1;
                end
            end else if (accept) begin
                pend_n = 1'b1;
            end
            default:  state_n = S_IDLE;
        endcase
    end

    // tx and busy are registered from the next state so they move with it
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shreg_n[0];
            S_PARITY: tx_n = par_n;
            default:  tx_n = 1'b1;
        endcase
        busy_n = (state_n != S_IDLE);
    end
endmodule
